// File: rtl/skin_thr_pkg.sv
// skin_thr_pkg
//   Shared constants for the skin-segmentation threshold controller:
//   threshold count, selection indices and the reset default of every
//   threshold, plus the selection wrap helper.
package skin_thr_pkg;

  localparam int NUM_THR = 6;

  localparam logic [2:0] SEL_Y_LO  = 3'd0;
  localparam logic [2:0] SEL_Y_HI  = 3'd1;
  localparam logic [2:0] SEL_CB_LO = 3'd2;
  localparam logic [2:0] SEL_CB_HI = 3'd3;
  localparam logic [2:0] SEL_CR_LO = 3'd4;
  localparam logic [2:0] SEL_CR_HI = 3'd5;

  localparam logic [7:0] DEF_Y_LO  = 8'd50;
  localparam logic [7:0] DEF_Y_HI  = 8'd255;
  localparam logic [7:0] DEF_CB_LO = 8'd77;
  localparam logic [7:0] DEF_CB_HI = 8'd132;
  localparam logic [7:0] DEF_CR_LO = 8'd135;
  localparam logic [7:0] DEF_CR_HI = 8'd173;

  // Defaults in selection-index order, so reset loops can index by sel.
  localparam logic [7:0] DEF_THR [NUM_THR] = '{
    DEF_Y_LO, DEF_Y_HI, DEF_CB_LO, DEF_CB_HI, DEF_CR_LO, DEF_CR_HI
  };

  function automatic logic [2:0] next_sel(input logic [2:0] cur);
    return (cur == SEL_CR_HI) ? SEL_Y_LO : cur + 3'd1;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// key_debounce
//   Synchronises one raw push-button, debounces it and emits a one-cycle
//   event on the debounced press. With THR_AUTOREPEAT_EN defined and
//   REPEAT_EN set, a held key also emits repeat events.
// Ports
//   clk        in  clock
//   rst        in  asynchronous active-high reset
//   key_raw    in  raw button level, high = pressed
//   key_event  out one-cycle pulse per press (and per repeat)
// Configuration macro: THR_AUTOREPEAT_EN
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000
`ifdef THR_AUTOREPEAT_EN
  , parameter bit REPEAT_EN     = 1'b1,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
`endif
) (
  input  logic clk,
  input  logic rst,
  input  logic key_raw,
  output logic key_event
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             prev_q, prev_d;
  logic             event_q, event_d;
  logic             rpt_fire;

`ifdef THR_AUTOREPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RPT_W   = $clog2(RPT_MAX + 1);

  logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;
  logic             rpt_armed_q, rpt_armed_d;
  logic [RPT_W-1:0] rpt_limit;

  // Counts cycles while the key stays held after its press event; the first
  // repeat waits REPEAT_DELAY, later ones REPEAT_PERIOD.
  always_comb begin
    rpt_cnt_d   = '0;
    rpt_armed_d = 1'b0;
    rpt_fire    = 1'b0;
    rpt_limit   = rpt_armed_q ? RPT_W'(REPEAT_PERIOD - 1) : RPT_W'(REPEAT_DELAY - 1);
    if (level_q && prev_q) begin
      rpt_armed_d = rpt_armed_q;
      if (rpt_cnt_q == rpt_limit) begin
        rpt_fire    = REPEAT_EN;
        rpt_armed_d = 1'b1;
      end else begin
        rpt_cnt_d = rpt_cnt_q + RPT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rpt_cnt_q   <= '0;
      rpt_armed_q <= 1'b0;
    end else begin
      rpt_cnt_q   <= rpt_cnt_d;
      rpt_armed_q <= rpt_armed_d;
    end
  end
`else
  assign rpt_fire = 1'b0;
`endif

  // The debounced level flips only after DEBOUNCE_CYCLES consecutive
  // synchronised samples disagree with it; any agreeing sample restarts.
  always_comb begin
    sync1_d = key_raw;
    sync2_d = sync1_q;
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
    prev_d  = level_q;
    event_d = (level_q & ~prev_q) | rpt_fire;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      prev_q  <= 1'b0;
      event_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      prev_q  <= prev_d;
      event_q <= event_d;
    end
  end

  assign key_event = event_q;

endmodule

// File: rtl/skin_threshold_ctrl.sv
// skin_threshold_ctrl
//   Owns the six YCbCr skin thresholds. Three debounced keys select and
//   adjust a working copy; the working set is committed to the active
//   outputs only at frame start so a frame never mixes two sets.
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   key_dec/key_inc/key_sel  raw buttons (high = pressed)
//   frame_start              one-cycle pulse at start of frame
//   sel                      selected threshold index 0..5
//   y_lo..cr_hi              active thresholds
//   cfg_update               one-cycle pulse when a changed set is committed
// Configuration macro: THR_AUTOREPEAT_EN (auto-repeat on held dec/inc)
module skin_threshold_ctrl
  import skin_thr_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000
`ifdef THR_AUTOREPEAT_EN
  , parameter int REPEAT_DELAY  = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_dec,
  input  logic       key_inc,
  input  logic       key_sel,
  input  logic       frame_start,
  output logic [2:0] sel,
  output logic [7:0] y_lo,
  output logic [7:0] y_hi,
  output logic [7:0] cb_lo,
  output logic [7:0] cb_hi,
  output logic [7:0] cr_lo,
  output logic [7:0] cr_hi,
  output logic       cfg_update
);

  logic ev_dec, ev_inc, ev_sel;

  logic [7:0] wk_q  [NUM_THR];
  logic [7:0] wk_d  [NUM_THR];
  logic [7:0] act_q [NUM_THR];
  logic [7:0] act_d [NUM_THR];
  logic [2:0] sel_q, sel_d;
  logic       dirty_q, dirty_d;
  logic       cfg_update_q, cfg_update_d;

  logic [7:0] cur_val;
  logic [7:0] pair_val;
  logic       is_hi;
  logic       applied;

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
`ifdef THR_AUTOREPEAT_EN
    , .REPEAT_EN(1'b1), .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD)
`endif
  ) u_deb_dec (.clk(clk), .rst(rst), .key_raw(key_dec), .key_event(ev_dec));

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
`ifdef THR_AUTOREPEAT_EN
    , .REPEAT_EN(1'b1), .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD)
`endif
  ) u_deb_inc (.clk(clk), .rst(rst), .key_raw(key_inc), .key_event(ev_inc));

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
`ifdef THR_AUTOREPEAT_EN
    , .REPEAT_EN(1'b0), .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD)
`endif
  ) u_deb_sel (.clk(clk), .rst(rst), .key_raw(key_sel), .key_event(ev_sel));

  // Lo/hi partners share an index pair (even = lo, odd = hi), so the
  // partner of the selected threshold is sel with bit 0 flipped. The
  // adjust uses the pre-advance sel, and a commit copies the working set
  // as it stood before this cycle's edit, which leaves that edit pending.
  always_comb begin
    wk_d         = wk_q;
    act_d        = act_q;
    sel_d        = sel_q;
    dirty_d      = dirty_q;
    cfg_update_d = 1'b0;
    applied      = 1'b0;
    is_hi        = sel_q[0];
    cur_val      = wk_q[sel_q];
    pair_val     = wk_q[sel_q ^ 3'd1];

    if (ev_inc && !ev_dec && cur_val != 8'd255 && (is_hi || cur_val < pair_val)) begin
      wk_d[sel_q] = cur_val + 8'd1;
      applied     = 1'b1;
    end
    if (ev_dec && !ev_inc && cur_val != 8'd0 && (!is_hi || cur_val > pair_val)) begin
      wk_d[sel_q] = cur_val - 8'd1;
      applied     = 1'b1;
    end

    if (ev_sel) begin
      sel_d = next_sel(sel_q);
    end

    if (frame_start && dirty_q) begin
      act_d        = wk_q;
      cfg_update_d = 1'b1;
      dirty_d      = applied;
    end else if (applied) begin
      dirty_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_THR; i++) begin
        wk_q[i]  <= DEF_THR[i];
        act_q[i] <= DEF_THR[i];
      end
      sel_q        <= SEL_Y_LO;
      dirty_q      <= 1'b0;
      cfg_update_q <= 1'b0;
    end else begin
      wk_q         <= wk_d;
      act_q        <= act_d;
      sel_q        <= sel_d;
      dirty_q      <= dirty_d;
      cfg_update_q <= cfg_update_d;
    end
  end

  assign sel        = sel_q;
  assign y_lo       = act_q[SEL_Y_LO];
  assign y_hi       = act_q[SEL_Y_HI];
  assign cb_lo      = act_q[SEL_CB_LO];
  assign cb_hi      = act_q[SEL_CB_HI];
  assign cr_lo      = act_q[SEL_CR_LO];
  assign cr_hi      = act_q[SEL_CR_HI];
  assign cfg_update = cfg_update_q;

endmodule

// File: tb/tb_skin_threshold_ctrl.sv
// tb_skin_threshold_ctrl
//   Directed bench for skin_threshold_ctrl with DEBOUNCE_CYCLES=4 (and
//   REPEAT_DELAY=20, REPEAT_PERIOD=5 when THR_AUTOREPEAT_EN is defined).
//   Inputs change and outputs are sampled 1 time unit after a rising edge.
module tb_skin_threshold_ctrl;

`ifdef THR_AUTOREPEAT_EN
  localparam logic [7:0] EXP_CB_HI_HOLD = 8'd126;
`else
  localparam logic [7:0] EXP_CB_HI_HOLD = 8'd131;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       key_dec = 1'b0;
  logic       key_inc = 1'b0;
  logic       key_sel = 1'b0;
  logic       frame_start = 1'b0;
  logic [2:0] sel;
  logic [7:0] y_lo, y_hi, cb_lo, cb_hi, cr_lo, cr_hi;
  logic       cfg_update;

  int n_checks = 0;
  int n_fail   = 0;

  skin_threshold_ctrl #(
    .DEBOUNCE_CYCLES(4)
`ifdef THR_AUTOREPEAT_EN
    , .REPEAT_DELAY(20), .REPEAT_PERIOD(5)
`endif
  ) dut (
    .clk(clk), .rst(rst),
    .key_dec(key_dec), .key_inc(key_inc), .key_sel(key_sel),
    .frame_start(frame_start),
    .sel(sel),
    .y_lo(y_lo), .y_hi(y_hi), .cb_lo(cb_lo), .cb_hi(cb_hi), .cr_lo(cr_lo), .cr_hi(cr_hi),
    .cfg_update(cfg_update)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hold the given keys for 'hold' cycles, then release and let them settle.
  task automatic press(input logic d, input logic i, input logic s, input int hold);
    key_dec = d;
    key_inc = i;
    key_sel = s;
    repeat (hold) tick();
    key_dec = 1'b0;
    key_inc = 1'b0;
    key_sel = 1'b0;
    repeat (12) tick();
  endtask

  // One frame_start pulse; returns the number of cfg_update cycles seen.
  task automatic do_frame(output int pulses);
    pulses = 0;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (cfg_update === 1'b1) pulses++;
      tick();
    end
  endtask

  task automatic test_reset();
    int p;
    rst = 1'b1;
    repeat (3) tick();
    n_checks++;
    if ({y_lo, y_hi, cb_lo, cb_hi, cr_lo, cr_hi, sel, cfg_update} !==
        {8'd50, 8'd255, 8'd77, 8'd132, 8'd135, 8'd173, 3'd0, 1'b0}) begin
      n_fail++;
      $display("[TB] FAIL reset_values got %0d/%0d/%0d/%0d/%0d/%0d sel=%0d upd=%b", y_lo, y_hi, cb_lo, cb_hi, cr_lo, cr_hi, sel, cfg_update);
    end
    rst = 1'b0;
    tick();
    do_frame(p);
    n_checks++;
    if (p !== 0) begin
      n_fail++;
      $display("[TB] FAIL reset_frame_pulse got %0d want 0", p);
    end
    n_checks++;
    if ({y_lo, y_hi, cb_lo, cb_hi, cr_lo, cr_hi} !== {8'd50, 8'd255, 8'd77, 8'd132, 8'd135, 8'd173}) begin
      n_fail++;
      $display("[TB] FAIL reset_frame_values changed y_lo=%0d cb_lo=%0d", y_lo, cb_lo);
    end
  endtask

  task automatic test_select();
    logic [2:0] exp_sel;
    press(1'b0, 1'b0, 1'b1, 2);
    n_checks++;
    if (sel !== 3'd0) begin
      n_fail++;
      $display("[TB] FAIL sel_glitch got %0d want 0", sel);
    end
    for (int n = 1; n <= 6; n++) begin
      press(1'b0, 1'b0, 1'b1, 12);
      exp_sel = (n == 6) ? 3'd0 : 3'(n);
      n_checks++;
      if (sel !== exp_sel) begin
        n_fail++;
        $display("[TB] FAIL sel_press_%0d got %0d want %0d", n, sel, exp_sel);
      end
    end
  endtask

  task automatic test_saturate_and_commit();
    int p;
    press(1'b0, 1'b0, 1'b1, 12);
    press(1'b0, 1'b1, 1'b0, 12);
    do_frame(p);
    n_checks++;
    if (p !== 0 || y_hi !== 8'd255) begin
      n_fail++;
      $display("[TB] FAIL y_hi_saturate got y_hi=%0d pulses=%0d want 255/0", y_hi, p);
    end
    repeat (5) press(1'b0, 1'b0, 1'b1, 12);
    repeat (3) press(1'b1, 1'b0, 1'b0, 12);
    n_checks++;
    if (y_lo !== 8'd50) begin
      n_fail++;
      $display("[TB] FAIL y_lo_precommit got %0d want 50", y_lo);
    end
    do_frame(p);
    n_checks++;
    if (y_lo !== 8'd47 || p !== 1) begin
      n_fail++;
      $display("[TB] FAIL y_lo_commit got y_lo=%0d pulses=%0d want 47/1", y_lo, p);
    end
  endtask

  task automatic test_ordering_guard();
    int p;
    repeat (4) press(1'b0, 1'b0, 1'b1, 12);
    n_checks++;
    if (sel !== 3'd4) begin
      n_fail++;
      $display("[TB] FAIL sel_to_cr_lo got %0d want 4", sel);
    end
    repeat (39) press(1'b0, 1'b1, 1'b0, 12);
    do_frame(p);
    n_checks++;
    if (cr_lo !== 8'd173 || cr_hi !== 8'd173 || p !== 1) begin
      n_fail++;
      $display("[TB] FAIL cr_lo_guard got cr_lo=%0d cr_hi=%0d pulses=%0d want 173/173/1", cr_lo, cr_hi, p);
    end
    press(1'b0, 1'b0, 1'b1, 12);
    press(1'b1, 1'b0, 1'b0, 12);
    do_frame(p);
    n_checks++;
    if (cr_hi !== 8'd173 || p !== 0) begin
      n_fail++;
      $display("[TB] FAIL cr_hi_guard got cr_hi=%0d pulses=%0d want 173/0", cr_hi, p);
    end
  endtask

  task automatic test_simultaneous();
    int p;
    press(1'b1, 1'b1, 1'b0, 12);
    do_frame(p);
    n_checks++;
    if (p !== 0 || {y_lo, y_hi, cb_lo, cb_hi, cr_lo, cr_hi} !== {8'd47, 8'd255, 8'd77, 8'd132, 8'd173, 8'd173}) begin
      n_fail++;
      $display("[TB] FAIL dec_inc_same_cycle pulses=%0d cr_hi=%0d want 0/173", p, cr_hi);
    end
    repeat (3) press(1'b0, 1'b0, 1'b1, 12);
    n_checks++;
    if (sel !== 3'd2) begin
      n_fail++;
      $display("[TB] FAIL sel_to_cb_lo got %0d want 2", sel);
    end
    press(1'b0, 1'b1, 1'b1, 12);
    do_frame(p);
    n_checks++;
    if (cb_lo !== 8'd78 || sel !== 3'd3 || cb_hi !== 8'd132 || p !== 1) begin
      n_fail++;
      $display("[TB] FAIL sel_inc_same_cycle got cb_lo=%0d sel=%0d cb_hi=%0d pulses=%0d want 78/3/132/1", cb_lo, sel, cb_hi, p);
    end
  endtask

  task automatic test_hold();
    int p;
    press(1'b1, 1'b0, 1'b0, 43);
    repeat (3) tick();
    do_frame(p);
    n_checks++;
    if (cb_hi !== EXP_CB_HI_HOLD || p !== 1) begin
      n_fail++;
      $display("[TB] FAIL cb_hi_hold got %0d pulses=%0d want %0d/1", cb_hi, p, EXP_CB_HI_HOLD);
    end
  endtask

  // The inc edit lands on the same edge that samples frame_start, so it
  // must stay pending until the following frame.
  task automatic test_commit_race();
    int p;
    key_inc = 1'b1;
    repeat (7) tick();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    n_checks++;
    if (cfg_update !== 1'b0 || cb_hi !== EXP_CB_HI_HOLD) begin
      n_fail++;
      $display("[TB] FAIL race_no_commit got upd=%b cb_hi=%0d want 0/%0d", cfg_update, cb_hi, EXP_CB_HI_HOLD);
    end
    repeat (8) tick();
    key_inc = 1'b0;
    repeat (12) tick();
    do_frame(p);
    n_checks++;
    if (cb_hi !== EXP_CB_HI_HOLD + 8'd1 || p !== 1) begin
      n_fail++;
      $display("[TB] FAIL race_late_commit got cb_hi=%0d pulses=%0d want %0d/1", cb_hi, p, EXP_CB_HI_HOLD + 8'd1);
    end
    do_frame(p);
    n_checks++;
    if (p !== 0) begin
      n_fail++;
      $display("[TB] FAIL dirty_cleared pulses=%0d want 0", p);
    end
  endtask

  task automatic test_reset_midframe();
    rst = 1'b1;
    #1;
    n_checks++;
    if ({y_lo, y_hi, cb_lo, cb_hi, cr_lo, cr_hi, sel} !==
        {8'd50, 8'd255, 8'd77, 8'd132, 8'd135, 8'd173, 3'd0}) begin
      n_fail++;
      $display("[TB] FAIL reset_midframe got %0d/%0d/%0d/%0d/%0d/%0d sel=%0d", y_lo, y_hi, cb_lo, cb_hi, cr_lo, cr_hi, sel);
    end
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_select();
    test_saturate_and_commit();
    test_ordering_guard();
    test_simultaneous();
    test_hold();
    test_commit_race();
    test_reset_midframe();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
